// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
package memory_arbiter_pkg;

    // Transaction FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // Port identifiers used for ownership and last-grant tracking
    localparam logic PORT_INST = 1'b0;
    localparam logic PORT_DATA = 1'b1;

    // Counter width for the watchdog; at least one bit even when disabled
    function automatic int wd_cnt_width(input int timeout_cycles);
        return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/arbiter_grant_select.sv
// Combinational winner selection between the instruction and data ports.
// Build option: ARBITER_ROUND_ROBIN_EN selects round-robin, otherwise the
// data port has fixed priority and no last-grant input exists.
module arbiter_grant_select
    import memory_arbiter_pkg::*;
(
    input  logic inst_req,
    input  logic data_req,
`ifdef ARBITER_ROUND_ROBIN_EN
    input  logic last_grant,
`endif
    output logic winner
);

    // Pick the owner; only meaningful when at least one request is high
    always_comb begin
        winner = PORT_INST;
`ifdef ARBITER_ROUND_ROBIN_EN
        if (inst_req && data_req) winner = ~last_grant;
        else if (data_req)        winner = PORT_DATA;
        else                      winner = PORT_INST;
`else
        if (data_req)             winner = PORT_DATA;
        else if (inst_req)        winner = PORT_INST;
`endif
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one single-port memory between instruction and data ports.
// One transaction in flight: grant, issue, wait for response, return.
// A watchdog releases the bus when memory never answers.
// Build option: ARBITER_ROUND_ROBIN_EN (round-robin on contention;
// undefined gives fixed data-port priority).
module memory_port_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  inst_read,
    input  logic                  inst_write,
    input  logic [ADDR_WIDTH-1:0] inst_address,
    input  logic [DATA_WIDTH-1:0] inst_write_data,
    output logic [DATA_WIDTH-1:0] inst_read_data,
    output logic                  inst_response,

    input  logic                  data_read,
    input  logic                  data_write,
    input  logic [ADDR_WIDTH-1:0] data_address,
    input  logic [DATA_WIDTH-1:0] data_write_data,
    output logic [DATA_WIDTH-1:0] data_read_data,
    output logic                  data_response,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_response,

    output logic                  timeout_error
);

    localparam int          CNT_W  = wd_cnt_width(TIMEOUT_CYCLES);
    localparam bit          WD_EN  = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);

    arb_state_e       state_q, state_d;
    logic             owner_q;
    logic             op_write_q;
    logic             timed_out_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_hit;
    logic             inst_req, data_req;
    logic             winner;
    logic             last_grant;

    assign inst_req = inst_read | inst_write;
    assign data_req = data_read | data_write;

`ifdef ARBITER_ROUND_ROBIN_EN
    logic last_grant_q;
    assign last_grant = last_grant_q;

    // Remember the most recent winner so contention alternates
    always_ff @(posedge clk) begin
        if (reset)
            last_grant_q <= PORT_DATA;
        else if (state_q == IDLE && (inst_req || data_req))
            last_grant_q <= winner;
    end
`else
    assign last_grant = PORT_DATA;
`endif

    arbiter_grant_select u_grant (
        .inst_req   (inst_req),
        .data_req   (data_req),
`ifdef ARBITER_ROUND_ROBIN_EN
        .last_grant (last_grant),
`endif
        .winner     (winner)
    );

    // The ISSUE cycle counts as the first waited cycle, so RESP lands
    // TIMEOUT_CYCLES cycles after ISSUE when memory stays silent.
    assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign timeout_hit = WD_EN && (cnt_inc >= CNT_LIM);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (inst_req || data_req) state_d = ISSUE;
            ISSUE: state_d = mem_response ? RESP : WAIT;
            WAIT:  if (mem_response || timeout_hit) state_d = RESP;
            RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from state and ownership
    always_comb begin
        mem_read      = (state_q == ISSUE) && !op_write_q;
        mem_write     = (state_q == ISSUE) &&  op_write_q;
        inst_response = (state_q == RESP) && (owner_q == PORT_INST);
        data_response = (state_q == RESP) && (owner_q == PORT_DATA);
        timeout_error = (state_q == RESP) && timed_out_q;
    end

    // Watchdog counter: idle at zero, saturating count while waiting
    always_ff @(posedge clk) begin
        if (reset || state_q == IDLE || state_q == RESP)
            cnt_q <= '0;
        else
            cnt_q <= cnt_inc;
    end

    // Grant latch, memory request registers and per-port read data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q        <= PORT_INST;
            op_write_q     <= 1'b0;
            timed_out_q    <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            inst_read_data <= '0;
            data_read_data <= '0;
        end else begin
            if (state_q == IDLE && (inst_req || data_req)) begin
                owner_q     <= winner;
                timed_out_q <= 1'b0;
                if (winner == PORT_DATA) begin
                    op_write_q     <= data_write;
                    mem_address    <= data_address;
                    mem_write_data <= data_write_data;
                end else begin
                    op_write_q     <= inst_write;
                    mem_address    <= inst_address;
                    mem_write_data <= inst_write_data;
                end
            end
            if ((state_q == ISSUE || state_q == WAIT) && mem_response) begin
                if (owner_q == PORT_DATA) data_read_data <= mem_read_data;
                else                      inst_read_data <= mem_read_data;
            end else if (state_q == WAIT && timeout_hit) begin
                timed_out_q <= 1'b1;
                if (owner_q == PORT_DATA) data_read_data <= '0;
                else                      inst_read_data <= '0;
            end
        end
    end

endmodule
